alu_mdu_ctrl: RTL and testbench
===============================

# alu_mdu_ctrl

Parametrised, sequential successor to the single-cycle ALU control decoder. It produces the 4-bit ALU operation for R-type, I-type, load, store and branch instructions. It also adds the RV32M/RV64M multiply/divide ops, executed on an internal iterative radix-2 datapath. It sits between the main decoder and the execute stage and stalls the core while a multiply/divide is in flight.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64)
- M_EXT, 1, 1 = M-extension enabled; 0 = M encodings decode as ADD and never stall

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  instruction fields and operands valid this cycle
- r_type, i_type, store, load, branch  in  1 each  one-hot instruction class
- func3  in  3  instruction funct3
- func7  in  7  instruction funct7 (full field)
- rs1_data, rs2_data  in  XLEN  operands
- flush_i  in  1  synchronous abort of an in-flight M op
- alu_op_o  out  4  ALU operation select (combinational)
- stall_o  out  1  core must hold the current instruction
- mdu_done_o  out  1  one-cycle pulse, mdu_result_o valid
- mdu_result_o  out  XLEN  M-op result

## Operation
- ALU op encoding: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 0110, OR 0111, AND 1000, SUB 1001.
- r_type, func7 = 0000000: func3 maps 000→ADD, 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL, 110→OR, 111→AND.
- r_type, func7 = 0100000: func3 000→SUB, 101→SRA, else ADD.
- i_type: func7 is ignored except when func3 = 101, where func7[5] selects SRA over SRL; otherwise same map as R-type.
- load, store → ADD.
- branch: func3 000/001→SUB, 100/101→SLT, 110/111→SLTU, other values→ADD.
- No class asserted → ADD. alu_op_o is combinational and latch-free.
- M op = M_EXT & valid_i & r_type & func7 = 0000001. func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. alu_op_o = ADD during M ops.
- FSM: IDLE → CALC on M op; latches operands, func3 and sign flags; counter ← 0.
- CALC: one radix-2 step per cycle on absolute values. After XLEN steps → DONE.
- DONE: apply sign correction, pulse mdu_done_o → IDLE.
- Signed handling: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed, rs2 as unsigned. Product is 2·XLEN bits; MUL returns the low half, MULH* the high half.
- Divide by zero: quotient = all ones, remainder = rs1 (no sign correction).
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- flush_i in CALC → IDLE next cycle, no done pulse, result discarded. flush_i in IDLE or DONE is ignored.
- valid_i or field changes during CALC are ignored; latched values are used.

## Timing
- Reset values: state IDLE, stall_o 0, mdu_done_o 0, mdu_result_o 0, counter 0.
- stall_o = (IDLE & M op) | CALC.
- Start in cycle 0; CALC occupies cycles 1..XLEN; DONE at cycle XLEN+1 with stall_o = 0 and mdu_done_o = 1. The core advances and writes back in that cycle.
- mdu_result_o is registered and holds its value until the next DONE.
- A new M op is accepted in the cycle after DONE (back-to-back latency is XLEN+2 per op).
- Reset asserted mid-CALC → IDLE immediately (asynchronous); no done pulse after release.

## Structure
- Shared package alu_pkg: ALU op localparams, M-op func3 constants, FSM state enum (IDLE, CALC, DONE).
- Sub-module mdu_iter: iterative shift-add multiplier / restoring divider with counter, start/flush in, done/result out. The top level holds the decoder and stall logic.

## Test plan
- Decode sweep: r_type func3=000 func7=0100000 → 1001; i_type func3=000 func7=0100000 → 0000; i_type func3=101 func7=0100000 → 0110; branch func3=110 → 0011; store → 0000.
- MUL 7 × 0xFFFFFFFD (XLEN=32) → stall_o high for 33 cycles, mdu_done_o at cycle 33, result 0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV −7 / 0 → 0xFFFFFFFF; REM −7 / 2 → 0xFFFFFFFF.
- flush_i at CALC cycle 10 → stall_o low next cycle, no mdu_done_o; a following MUL 3 × 4 → 12.
- rst pulsed mid-CALC → all outputs 0 immediately; a new DIVU 100 / 7 after release → 14.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decoder and the iterative multiply/divide unit.
package alu_pkg;

   // ALU operation select encodings
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b0110;
   localparam logic [3:0] ALU_OR   = 4'b0111;
   localparam logic [3:0] ALU_AND  = 4'b1000;
   localparam logic [3:0] ALU_SUB  = 4'b1001;

   // funct7 values of interest
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // M-extension funct3 values
   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

   // Base funct3 -> ALU op map shared by R-type (funct7 = 0) and I-type
   function automatic logic [3:0] f3_base_op(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: shift-add multiplier and restoring
// divider on absolute operand values, sign-corrected on the way into DONE.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [2:0]      i_func3,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_idle,
   output logic            o_calc,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e          r_state;
   mdu_state_e          w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [2:0]          r_f3;
   logic                r_is_div;
   logic                r_neg_q;   // product / quotient must be negated
   logic                r_neg_r;   // remainder takes the dividend's sign
   logic                r_div0;
   logic                r_ovf;
   logic [XLEN-1:0]     r_rs1;
   logic [XLEN-1:0]     r_b;       // multiplicand (mul) or divisor (div)
   logic [XLEN-1:0]     r_hi;      // product high half / partial remainder
   logic [XLEN-1:0]     r_lo;      // multiplier bits / dividend->quotient
   logic [XLEN-1:0]     r_result;

   logic                w_sgn1;
   logic                w_sgn2;
   logic                w_is_div;
   logic [XLEN-1:0]     w_abs1;
   logic [XLEN-1:0]     w_abs2;
   logic                w_last;
   logic [XLEN:0]       w_sum;
   logic [XLEN:0]       w_shl;
   logic [XLEN:0]       w_diff;
   logic [XLEN-1:0]     w_hi_nxt;
   logic [XLEN-1:0]     w_lo_nxt;
   logic [2*XLEN-1:0]   w_prod_raw;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_res;

   // Operand sign interpretation; plain MUL is sign-agnostic in its low half
   assign w_is_div = i_func3[2];
   assign w_sgn1   = i_rs1[XLEN-1] & ((i_func3 == M_MULH) | (i_func3 == M_MULHSU) |
                                      (i_func3 == M_DIV)  | (i_func3 == M_REM));
   assign w_sgn2   = i_rs2[XLEN-1] & ((i_func3 == M_MULH) | (i_func3 == M_DIV) |
                                      (i_func3 == M_REM));
   assign w_abs1   = w_sgn1 ? -i_rs1 : i_rs1;
   assign w_abs2   = w_sgn2 ? -i_rs2 : i_rs2;
   assign w_last   = (r_state == ST_CALC) && (r_cnt == CW'(XLEN - 1));

   // One radix-2 step of either the multiplier or the divider
   always_comb begin
      w_sum    = '0;
      w_shl    = '0;
      w_diff   = '0;
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_is_div) begin
         w_shl  = {r_hi, r_lo[XLEN-1]};
         w_diff = w_shl - {1'b0, r_b};
         if (!w_diff[XLEN]) begin
            w_hi_nxt = w_diff[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
         end else begin
            w_hi_nxt = w_shl[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         w_sum    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
         w_hi_nxt = w_sum[XLEN:1];
         w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   assign w_prod_raw = {w_hi_nxt, w_lo_nxt};
   assign w_prod     = r_neg_q ? -w_prod_raw : w_prod_raw;
   assign w_quo      = r_neg_q ? -w_lo_nxt : w_lo_nxt;
   assign w_rem      = r_neg_r ? -w_hi_nxt : w_hi_nxt;

   // Final result selection with divide-by-zero and overflow overrides
   always_comb begin
      w_res = '0;
      case (r_f3)
         M_MUL:                     w_res = w_prod[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
         M_DIV, M_DIVU: begin
            if (r_div0)     w_res = '1;
            else if (r_ovf) w_res = MIN_VAL;
            else            w_res = w_quo;
         end
         default: begin
            if (r_div0)     w_res = r_rs1;
            else if (r_ovf) w_res = '0;
            else            w_res = w_rem;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state and status outputs; flush only matters while calculating
   always_comb begin
      w_state_nxt = r_state;
      o_idle      = 1'b0;
      o_calc      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_idle = 1'b1;
            if (i_start) w_state_nxt = ST_CALC;
         end
         ST_CALC: begin
            o_calc = 1'b1;
            if (i_flush)     w_state_nxt = ST_IDLE;
            else if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand latch at start, iteration in CALC, result capture on the last step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_f3     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
         r_rs1    <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
      end else if ((r_state == ST_IDLE) && i_start) begin
         r_cnt    <= '0;
         r_f3     <= i_func3;
         r_is_div <= w_is_div;
         r_neg_q  <= w_sgn1 ^ w_sgn2;
         r_neg_r  <= w_sgn1;
         r_div0   <= w_is_div && (i_rs2 == '0);
         r_ovf    <= (i_func3 == M_DIV || i_func3 == M_REM) &&
                     (i_rs1 == MIN_VAL) && (i_rs2 == '1);
         r_rs1    <= i_rs1;
         r_b      <= w_is_div ? w_abs2 : w_abs1;
         r_hi     <= '0;
         r_lo     <= w_is_div ? w_abs1 : w_abs2;
      end else if ((r_state == ST_CALC) && !i_flush) begin
         r_cnt <= r_cnt + CW'(1);
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         if (w_last) r_result <= w_res;
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder with an attached iterative M-extension unit; stalls the
// core while a multiply/divide is in flight.
module alu_mdu_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int M_EXT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic            r_type,
   input  logic            i_type,
   input  logic            store,
   input  logic            load,
   input  logic            branch,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush_i,
   output logic [3:0]      alu_op_o,
   output logic            stall_o,
   output logic            mdu_done_o,
   output logic [XLEN-1:0] mdu_result_o
);

   logic       w_mop;
   logic       w_idle;
   logic       w_calc;
   logic [3:0] w_alu_op;

   assign w_mop = (M_EXT != 0) && valid_i && r_type && (func7 == F7_MULDIV);

   // ALU operation decode; any unlisted combination (including M ops) is ADD
   always_comb begin
      w_alu_op = ALU_ADD;
      if (r_type) begin
         if (func7 == F7_BASE) begin
            w_alu_op = f3_base_op(func3);
         end else if (func7 == F7_ALT) begin
            if (func3 == 3'b000)      w_alu_op = ALU_SUB;
            else if (func3 == 3'b101) w_alu_op = ALU_SRA;
         end
      end else if (i_type) begin
         if (func3 == 3'b101) w_alu_op = func7[5] ? ALU_SRA : ALU_SRL;
         else                 w_alu_op = f3_base_op(func3);
      end else if (branch) begin
         case (func3)
            3'b000, 3'b001: w_alu_op = ALU_SUB;
            3'b100, 3'b101: w_alu_op = ALU_SLT;
            3'b110, 3'b111: w_alu_op = ALU_SLTU;
            default:        w_alu_op = ALU_ADD;
         endcase
      end
   end

   assign alu_op_o = w_alu_op;

   // Hold the core from the issue cycle until the last CALC step
   assign stall_o = (w_idle & w_mop) | w_calc;

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_idle & w_mop),
      .i_flush  (flush_i),
      .i_func3  (func3),
      .i_rs1    (rs1_data),
      .i_rs2    (rs2_data),
      .o_idle   (w_idle),
      .o_calc   (w_calc),
      .o_done   (mdu_done_o),
      .o_result (mdu_result_o)
   );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl (XLEN = 32): directed decode and M-op
// cases from the feature list plus randomized ops against a plain-arithmetic model.
module tb_alu_mdu_ctrl;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_i;
   logic            r_type, i_type, store, load, branch;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            flush_i;
   logic [3:0]      alu_op_o;
   logic            stall_o;
   logic            mdu_done_o;
   logic [XLEN-1:0] mdu_result_o;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_mdu_ctrl #(.XLEN(XLEN), .M_EXT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .r_type       (r_type),
      .i_type       (i_type),
      .store        (store),
      .load         (load),
      .branch       (branch),
      .func3        (func3),
      .func7        (func7),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .flush_i      (flush_i),
      .alu_op_o     (alu_op_o),
      .stall_o      (stall_o),
      .mdu_done_o   (mdu_done_o),
      .mdu_result_o (mdu_result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference M-op results computed with wide native arithmetic
   function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   // Reference ALU decode from the instruction-class rules
   function automatic logic [3:0] ref_dec(input logic rt, input logic it, input logic ls,
                                          input logic br, input logic [2:0] f3,
                                          input logic [6:0] f7);
      logic [3:0] base [8];
      base = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
      if (rt) begin
         if (f7 == 7'h00) return base[f3];
         if (f7 == 7'h20) return (f3 == 3'd0) ? 4'd9 : (f3 == 3'd5) ? 4'd6 : 4'd0;
         return 4'd0;
      end
      if (it) begin
         if (f3 == 3'd5) return f7[5] ? 4'd6 : 4'd5;
         return base[f3];
      end
      if (ls) return 4'd0;
      if (br) begin
         if (f3 <= 3'd1) return 4'd9;
         if (f3 == 3'd4 || f3 == 3'd5) return 4'd2;
         if (f3 >= 3'd6) return 4'd3;
         return 4'd0;
      end
      return 4'd0;
   endfunction

   task automatic set_cls(input int cls);
      r_type = (cls == 1);
      i_type = (cls == 2);
      load   = (cls == 3);
      store  = (cls == 4);
      branch = (cls == 5);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one M op, scramble fields during CALC, check timing and result
   task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
      logic [31:0] exp;
      int cyc, stalls;
      exp = ref_m(f3, a, b);
      set_cls(1);
      valid_i  = 1'b1;
      func7    = 7'b0000001;
      func3    = f3;
      rs1_data = a;
      rs2_data = b;
      cyc      = 0;
      stalls   = 0;
      #1;
      check({tag, ":aluop"}, 64'(alu_op_o), 64'd0);
      while (!mdu_done_o && cyc <= 40) begin
         if (stall_o) stalls++;
         tick();
         cyc++;
         if (cyc < XLEN) begin
            func3    = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
         end else begin
            valid_i = 1'b0;
         end
         #1;
      end
      check({tag, ":done_cyc"}, 64'(cyc), 64'(XLEN + 1));
      check({tag, ":stalls"}, 64'(stalls), 64'(XLEN + 1));
      check({tag, ":stall_at_done"}, 64'(stall_o), 64'd0);
      check({tag, ":result"}, 64'(mdu_result_o), 64'(exp));
      valid_i = 1'b0;
      set_cls(0);
      tick();
      check({tag, ":done_pulse"}, 64'(mdu_done_o), 64'd0);
      check({tag, ":hold"}, 64'(mdu_result_o), 64'(exp));
   endtask

   // Start an op and advance to the given CALC cycle index
   task automatic start_to(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int stop_cyc);
      set_cls(1);
      valid_i  = 1'b1;
      func7    = 7'b0000001;
      func3    = f3;
      rs1_data = a;
      rs2_data = b;
      for (int c = 0; c < stop_cyc; c++) tick();
   endtask

   task automatic no_done_for(input string tag, input int n);
      int seen;
      seen = 0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (mdu_done_o) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] pick [6];
      int          cls;
      logic [6:0]  f7v;
      logic [2:0]  f3v;

      rst = 1'b1; valid_i = 1'b0; set_cls(0); func3 = '0; func7 = '0;
      rs1_data = '0; rs2_data = '0; flush_i = 1'b0;
      tick(); tick();
      check("rst:stall", 64'(stall_o), 64'd0);
      check("rst:done", 64'(mdu_done_o), 64'd0);
      check("rst:result", 64'(mdu_result_o), 64'd0);
      check("rst:aluop", 64'(alu_op_o), 64'd0);
      rst = 1'b0;
      tick();

      // Directed decode cases
      set_cls(1); func3 = 3'b000; func7 = 7'b0100000; #1 check("dec:r_sub", 64'(alu_op_o), 64'h9);
      set_cls(2); func3 = 3'b000; func7 = 7'b0100000; #1 check("dec:i_add", 64'(alu_op_o), 64'h0);
      set_cls(2); func3 = 3'b101; func7 = 7'b0100000; #1 check("dec:i_sra", 64'(alu_op_o), 64'h6);
      set_cls(2); func3 = 3'b101; func7 = 7'b0000000; #1 check("dec:i_srl", 64'(alu_op_o), 64'h5);
      set_cls(5); func3 = 3'b110; func7 = 7'b0000000; #1 check("dec:br_sltu", 64'(alu_op_o), 64'h3);
      set_cls(5); func3 = 3'b001;                     #1 check("dec:br_sub", 64'(alu_op_o), 64'h9);
      set_cls(4); func3 = 3'b111;                     #1 check("dec:store", 64'(alu_op_o), 64'h0);
      set_cls(1); func3 = 3'b110; func7 = 7'b0000000; #1 check("dec:r_or", 64'(alu_op_o), 64'h7);
      set_cls(0); func3 = 3'b001;                     #1 check("dec:none", 64'(alu_op_o), 64'h0);

      // Random decode sweep (valid_i low so no M op is launched)
      for (int k = 0; k < 40; k++) begin
         cls = int'($urandom_range(0, 5));
         f3v = 3'($urandom);
         case ($urandom_range(0, 3))
            0:       f7v = 7'h00;
            1:       f7v = 7'h20;
            2:       f7v = 7'h01;
            default: f7v = 7'($urandom);
         endcase
         set_cls(cls); func3 = f3v; func7 = f7v;
         #1 check("dec:rand", 64'(alu_op_o), 64'(ref_dec(cls == 1, cls == 2,
                                                     cls == 3 || cls == 4, cls == 5, f3v, f7v)));
      end
      set_cls(0);
      tick();

      // Directed M ops
      run_m("mul",   3'd0, 32'd7,          32'hFFFF_FFFD);
      run_m("mulhu", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_m("divov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
      run_m("remov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
      run_m("divu0", 3'd5, 32'd5,          32'd0);
      run_m("remu0", 3'd7, 32'd5,          32'd0);
      run_m("div0",  3'd4, -32'sd7,        32'd0);
      run_m("remneg",3'd6, -32'sd7,        32'd2);

      // Flush at CALC cycle 10
      start_to(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; valid_i = 1'b0; set_cls(0);
      #1;
      check("flush:stall", 64'(stall_o), 64'd0);
      check("flush:done", 64'(mdu_done_o), 64'd0);
      no_done_for("flush:no_done", 40);
      run_m("mul_after_flush", 3'd0, 32'd3, 32'd4);

      // Reset mid-CALC
      start_to(3'd4, 32'd1000, 32'd3, 5);
      rst = 1'b1; valid_i = 1'b0; set_cls(0);
      #1;
      check("midrst:stall", 64'(stall_o), 64'd0);
      check("midrst:done", 64'(mdu_done_o), 64'd0);
      check("midrst:result", 64'(mdu_result_o), 64'd0);
      check("midrst:aluop", 64'(alu_op_o), 64'd0);
      tick(); tick();
      rst = 1'b0;
      no_done_for("midrst:no_done", 40);
      run_m("divu_after_rst", 3'd5, 32'd100, 32'd7);

      // Randomized M ops with corner-biased operands
      for (int k = 0; k < 14; k++) begin
         pick = '{$urandom, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'($urandom_range(0, 99))};
         run_m("rand", 3'($urandom), pick[$urandom_range(0, 5)], pick[$urandom_range(0, 5)]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
